// File: rtl/pxconv_lb_pkg.sv
// pxconv_lb_pkg: types and constants shared by the pixel-converter line buffer.
//   mode_e  : grey conversion modes carried with each pixel beat
//   state_e : burst request FSM states
//   LUMA_*  : weights for the luma conversion, which sum to 256 so that >>8 normalises
package pxconv_lb_pkg;

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_LUMA = 2'd1,
    MODE_PASS = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic [7:0] LUMA_R_C = 8'd77;
  localparam logic [7:0] LUMA_G_C = 8'd150;
  localparam logic [7:0] LUMA_B_C = 8'd29;

endpackage

// File: rtl/pxconv_lb_if.sv
// pxconv_lb_if: AXI read-path handshake between the AXI master and pxconv_lb.
//   axi_to_pxconv_data        : 16-bit pixel beat          (master -> converter)
//   axi_to_pxconv_valid       : beat valid                 (master -> converter)
//   pxconv_to_axi_ready_to_rd : request one burst          (converter -> master)
//   pxconv_to_axi_mst_length  : burst length in bytes      (converter -> master)
interface pxconv_lb_if;
  logic [15:0] axi_to_pxconv_data;
  logic        axi_to_pxconv_valid;
  logic        pxconv_to_axi_ready_to_rd;
  logic [11:0] pxconv_to_axi_mst_length;

  modport master (
    output axi_to_pxconv_data,
    output axi_to_pxconv_valid,
    input  pxconv_to_axi_ready_to_rd,
    input  pxconv_to_axi_mst_length
  );

  modport slave (
    input  axi_to_pxconv_data,
    input  axi_to_pxconv_valid,
    output pxconv_to_axi_ready_to_rd,
    output pxconv_to_axi_mst_length
  );
endinterface

// File: rtl/pxconv_lb_grey.sv
// pxconv_grey: converts one 16-bit pixel to grey and registers the result.
// Optional feature macro: PXCONV_LB_LUMA_EN (weighted luma for mode 1; when
// undefined, no multipliers exist and mode 1 falls back to the average).
//   clk, rst : clock, synchronous active-high reset
//   en       : load a new result (a beat sits in the input register)
//   data_i   : pixel, RGB565 or grey8 in the low byte
//   mode_i   : conversion mode (3 decodes as average)
//   grey_o   : registered grey value, GREY_W bits
module pxconv_grey
  import pxconv_lb_pkg::*;
#(
  parameter int GREY_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [15:0]       data_i,
  input  logic [1:0]        mode_i,
  output logic [GREY_W-1:0] grey_o
);

  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [9:0]        avg_sum;
  logic [7:0]        grey8;
  logic [GREY_W-1:0] grey_d;
  logic [GREY_W-1:0] grey_q;

  // Components left-aligned to 8 bits (no bit replication).
  assign r8      = {data_i[15:11], 3'b000};
  assign g8      = {data_i[10:5],  2'b00};
  assign b8      = {data_i[4:0],   3'b000};
  assign avg_sum = {2'b00, r8} + {2'b00, g8} + {2'b00, b8};

`ifdef PXCONV_LB_LUMA_EN
  logic [15:0] luma_sum;
  assign luma_sum = {8'h00, LUMA_R_C} * {8'h00, r8}
                  + {8'h00, LUMA_G_C} * {8'h00, g8}
                  + {8'h00, LUMA_B_C} * {8'h00, b8};
`endif

  always_comb begin
    grey8 = 8'(avg_sum / 10'd3);
    case (mode_i)
      MODE_PASS: grey8 = data_i[7:0];
`ifdef PXCONV_LB_LUMA_EN
      MODE_LUMA: grey8 = luma_sum[15:8];
`endif
      default: ;
    endcase
  end

  // Keep the most significant bits; wider outputs are padded below the value.
  generate
    if (GREY_W <= 8) begin : g_trunc
      assign grey_d = grey8[7 -: GREY_W];
    end else begin : g_pad
      assign grey_d = {grey8, {(GREY_W-8){1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      grey_q <= '0;
    end else if (en) begin
      grey_q <= grey_d;
    end
  end

  assign grey_o = grey_q;

endmodule

// File: rtl/pxconv_lb.sv
// pxconv_lb: pixel-to-grey converter feeding an NLINES-deep circular line
// buffer in BRAM, with credit-based burst requests to the AXI read master.
// Optional feature macro: PXCONV_LB_LUMA_EN (see pxconv_grey).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   mode                  : conversion mode, sampled with each beat
//   axi (slave modport)   : pixel beats in, burst request / length out
//   line_release          : consumer has finished with the oldest line
//   pxconv_to_bram_*      : write port (we constant 1, wr_en strobe, addr, data)
//   wnd_in_bram           : all NLINES lines resident
//   frame_end             : pulses with the last pixel write of each frame
//   overrun               : sticky, a beat arrived outside a burst or without space
module pxconv_lb
  import pxconv_lb_pkg::*;
#(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int NLINES = 8,
  parameter int BURST  = 128,
  parameter int GREY_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  pxconv_lb_if.slave        axi,
  input  logic              line_release,
  output logic              pxconv_to_bram_we,
  output logic              pxconv_to_bram_wr_en,
  output logic [ADDR_W-1:0] pxconv_to_bram_addr,
  output logic [15:0]       pxconv_to_bram_data,
  output logic              wnd_in_bram,
  output logic              frame_end,
  output logic              overrun
);

  localparam int TOTAL = NLINES * HRES;
  localparam int HALF  = BURST / 2;
  localparam int FRAME = HRES * VRES;
  localparam int OCC_W = ADDR_W + 1;
  localparam int CNT_W = $clog2(HALF + 1);
  localparam int FR_W  = $clog2(FRAME);

  localparam logic [OCC_W:0]    TOTAL_C    = (OCC_W+1)'(TOTAL);
  localparam logic [OCC_W:0]    HALF_C     = (OCC_W+1)'(HALF);
  localparam logic [OCC_W-1:0]  TOTAL_O    = OCC_W'(TOTAL);
  localparam logic [OCC_W-1:0]  HRES_O     = OCC_W'(HRES);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT   = CNT_W'(HALF);
  localparam logic [FR_W-1:0]   FRAME_LAST = FR_W'(FRAME - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              ready_q, ready_d;
  logic              beat_vld_q, beat_vld_d;
  logic [15:0]       beat_data_q, beat_data_d;
  logic [1:0]        beat_mode_q, beat_mode_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              wnd_q, wnd_d;
  logic [FR_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              frame_end_q, frame_end_d;
  logic              overrun_q, overrun_d;

  logic              accept;
  logic              has_space;
  logic              rel_ok;
  logic [OCC_W:0]    committed_q;
  logic [OCC_W:0]    committed_d;
  logic [GREY_W-1:0] grey;

  always_comb begin
    // Occupancy counts a pixel one cycle after its write strobe, so the
    // committed total adds the beats still in the two pipeline registers.
    committed_q = (OCC_W+1)'(occ_q) + (OCC_W+1)'(beat_vld_q) + (OCC_W+1)'(wr_en_q);
    has_space   = committed_q < TOTAL_C;

    accept     = 1'b0;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (axi.axi_to_pxconv_valid) begin
          if (ready_q && has_space) begin
            accept     = 1'b1;
            state_d    = ST_BURST;
            beat_cnt_d = CNT_W'(1);
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (axi.axi_to_pxconv_valid) begin
          // Dropped beats still count toward the burst so it always closes.
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (has_space) begin
            accept = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
    endcase
    if ((state_d == ST_BURST) && (beat_cnt_d == HALF_CNT)) begin
      state_d = ST_IDLE;
    end

    beat_vld_d  = accept;
    beat_data_d = accept ? axi.axi_to_pxconv_data : beat_data_q;
    beat_mode_d = accept ? mode : beat_mode_q;

    wr_en_d     = beat_vld_q;
    wr_addr_d   = beat_vld_q ? ptr_q : wr_addr_q;
    ptr_d       = ptr_q;
    frame_cnt_d = frame_cnt_q;
    frame_end_d = 1'b0;
    if (beat_vld_q) begin
      ptr_d       = (ptr_q == ADDR_LAST) ? '0 : ptr_q + ADDR_W'(1);
      frame_end_d = (frame_cnt_q == FRAME_LAST);
      frame_cnt_d = frame_end_d ? '0 : frame_cnt_q + FR_W'(1);
    end

    // Releases that would underflow are ignored.
    rel_ok = line_release && (occ_q >= HRES_O);
    occ_d  = occ_q + OCC_W'(wr_en_q);
    if (rel_ok) begin
      occ_d = occ_d - HRES_O;
    end

    committed_d = (OCC_W+1)'(occ_d) + (OCC_W+1)'(accept) + (OCC_W+1)'(beat_vld_q);
    ready_d     = (state_d == ST_IDLE) && ((committed_d + HALF_C) <= TOTAL_C);
    wnd_d       = occ_q >= TOTAL_O;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      ready_q     <= 1'b0;
      beat_vld_q  <= 1'b0;
      beat_data_q <= '0;
      beat_mode_q <= '0;
      wr_en_q     <= 1'b0;
      ptr_q       <= '0;
      wr_addr_q   <= '0;
      occ_q       <= '0;
      wnd_q       <= 1'b0;
      frame_cnt_q <= '0;
      frame_end_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      ready_q     <= ready_d;
      beat_vld_q  <= beat_vld_d;
      beat_data_q <= beat_data_d;
      beat_mode_q <= beat_mode_d;
      wr_en_q     <= wr_en_d;
      ptr_q       <= ptr_d;
      wr_addr_q   <= wr_addr_d;
      occ_q       <= occ_d;
      wnd_q       <= wnd_d;
      frame_cnt_q <= frame_cnt_d;
      frame_end_q <= frame_end_d;
      overrun_q   <= overrun_d;
    end
  end

  pxconv_grey #(
    .GREY_W (GREY_W)
  ) u_grey (
    .clk    (clk),
    .rst    (rst),
    .en     (beat_vld_q),
    .data_i (beat_data_q),
    .mode_i (beat_mode_q),
    .grey_o (grey)
  );

  assign axi.pxconv_to_axi_ready_to_rd = ready_q;
  assign axi.pxconv_to_axi_mst_length  = 12'(BURST);
  assign pxconv_to_bram_we             = 1'b1;
  assign pxconv_to_bram_wr_en          = wr_en_q;
  assign pxconv_to_bram_addr           = wr_addr_q;
  assign pxconv_to_bram_data           = 16'(grey);
  assign wnd_in_bram                   = wnd_q;
  assign frame_end                     = frame_end_q;
  assign overrun                       = overrun_q;

endmodule

// File: tb/tb_pxconv_lb.sv
// tb_pxconv_lb: directed bench for pxconv_lb with HRES=16, VRES=4, NLINES=2,
// BURST=16 (8-beat bursts, 32-pixel window, 64-pixel frame).
module tb_pxconv_lb;
  localparam int HRES = 16, VRES = 4, NLINES = 2, BURST = 16, GREY_W = 8, ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              line_release;
  logic              we, wr_en, wnd, fend, ovr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;

  pxconv_lb_if axi_if ();

  pxconv_lb #(
    .HRES(HRES), .VRES(VRES), .NLINES(NLINES), .BURST(BURST), .GREY_W(GREY_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mode                 (mode),
    .axi                  (axi_if),
    .line_release         (line_release),
    .pxconv_to_bram_we    (we),
    .pxconv_to_bram_wr_en (wr_en),
    .pxconv_to_bram_addr  (addr),
    .pxconv_to_bram_data  (wdata),
    .wnd_in_bram          (wnd),
    .frame_end            (fend),
    .overrun              (ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fe_stray = 0;
  logic [ADDR_W-1:0] addr_log[$];
  logic [15:0]       data_log[$];
  logic              fe_log[$];
  logic [15:0]       pix_tab[8];
  logic [1:0]        mode_tab[8];
  logic [15:0]       exp_t2[8];

  // Write recorder: one entry per BRAM write strobe.
  always @(negedge clk) begin
    if (wr_en) begin
      addr_log.push_back(addr);
      data_log.push_back(wdata);
      fe_log.push_back(fend);
      $display("write addr=%0d data=%02h frame_end=%0d", addr, wdata, fend);
    end
    if (fend && !wr_en) fe_stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_tab(input logic [15:0] p, input logic [1:0] m);
    for (int i = 0; i < 8; i++) begin
      pix_tab[i]  = p;
      mode_tab[i] = m;
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!axi_if.pxconv_to_axi_ready_to_rd && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd1);
  endtask

  task automatic send_burst(input string tag);
    wait_ready(tag);
    for (int i = 0; i < 8; i++) begin
      axi_if.axi_to_pxconv_valid = 1'b1;
      axi_if.axi_to_pxconv_data  = pix_tab[i];
      mode                       = mode_tab[i];
      @(negedge clk);
      if (i == 0) chk({tag, "_rdy_low"}, 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    end
    axi_if.axi_to_pxconv_valid = 1'b0;
  endtask

  task automatic wait_write_addr(input int a, input string tag);
    int k = 0;
    while (!(wr_en && (addr == ADDR_W'(a))) && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(wr_en && (addr == ADDR_W'(a))), 32'd1);
  endtask

  task automatic pulse_release();
    line_release = 1'b1;
    @(negedge clk);
    line_release = 1'b0;
  endtask

  function automatic int fe_count(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (fe_log[i]) c++;
    return c;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    line_release = 1'b0;
    axi_if.axi_to_pxconv_valid = 1'b0;
    axi_if.axi_to_pxconv_data  = 16'h0000;
`ifdef PXCONV_LB_LUMA_EN
    exp_t2 = '{16'h52, 16'h4A, 16'h00, 16'h52, 16'h54, 16'h93, 16'h1C, 16'hAB};
`else
    exp_t2 = '{16'h52, 16'h52, 16'h00, 16'h52, 16'h54, 16'h54, 16'h52, 16'hAB};
`endif
    cycles(3);

    // Reset values
    chk("rst_ready",  32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    chk("rst_length", 32'(axi_if.pxconv_to_axi_mst_length), 32'd16);
    chk("rst_we",     32'(we), 32'd1);
    chk("rst_wr_en",  32'(wr_en), 32'd0);
    chk("rst_addr",   32'(addr), 32'd0);
    chk("rst_data",   32'(wdata), 32'd0);
    chk("rst_wnd",    32'(wnd), 32'd0);
    chk("rst_fend",   32'(fend), 32'd0);
    chk("rst_ovr",    32'(ovr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: fill the window with four bursts of 0xFFFF in mode 0 -> 0xF9
    fill_tab(16'hFFFF, 2'd0);
    for (int b = 0; b < 4; b++) send_burst("t1");
    wait_write_addr(31, "t1_last_write");
    chk("t1_wnd_w0", 32'(wnd), 32'd0);
    @(negedge clk);
    chk("t1_wnd_w1", 32'(wnd), 32'd0);
    @(negedge clk);
    chk("t1_wnd_w2", 32'(wnd), 32'd1);
    chk("t1_full_ready", 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    cycles(5);
    chk("t1_count", 32'(addr_log.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t1_addr%0d", i), 32'(addr_log[i]), 32'(i));
      chk($sformatf("t1_data%0d", i), 32'(data_log[i]), 32'h00F9);
    end
    chk("t1_ovr", 32'(ovr), 32'd0);

    // Test 3 / 2: release one line, then mixed-mode conversions at addresses 0..7
    pulse_release();
    pix_tab  = '{16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'h07E0, 16'h07E0, 16'h001F, 16'h12AB};
    mode_tab = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    send_burst("t2");

    // Test 4: release coincident with the final write of the next burst
    fill_tab(16'h0055, 2'd2);
    send_burst("t4");
    wait_write_addr(15, "t4_last_write");
    line_release = 1'b1;
    @(negedge clk);
    line_release = 1'b0;
    chk("t4_ready", 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd1);
    chk("t4_ovr", 32'(ovr), 32'd0);
    chk("t4_wnd", 32'(wnd), 32'd0);

    // Exactly 16 free pixels remain: two bursts refill the window
    fill_tab(16'h00AA, 2'd2);
    send_burst("t3b");
    send_burst("t3b");
    wait_write_addr(31, "t3b_last_write");
    cycles(3);
    chk("t3b_wnd", 32'(wnd), 32'd1);
    chk("t3b_ready", 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    chk("t3b_count", 32'(addr_log.size()), 32'd64);
    for (int i = 32; i < 64; i++) begin
      chk($sformatf("t3_addr%0d", i), 32'(addr_log[i]), 32'((i - 32) % 32));
      if (i < 40)      chk($sformatf("t2_data%0d", i), 32'(data_log[i]), 32'(exp_t2[i-32]));
      else if (i < 48) chk($sformatf("t4_data%0d", i), 32'(data_log[i]), 32'h0055);
      else             chk($sformatf("t3_data%0d", i), 32'(data_log[i]), 32'h00AA);
    end
    chk("fe_first_frame", 32'(fe_count(0, 62)), 32'd0);
    chk("fe_at_63", 32'(fe_log[63]), 32'd1);

    // Test 5: beat while idle and not ready is dropped; overrun sticks
    axi_if.axi_to_pxconv_valid = 1'b1;
    axi_if.axi_to_pxconv_data  = 16'h1234;
    mode = 2'd2;
    @(negedge clk);
    axi_if.axi_to_pxconv_valid = 1'b0;
    chk("t5_ovr_set", 32'(ovr), 32'd1);
    cycles(4);
    chk("t5_no_write", 32'(addr_log.size()), 32'd64);
    chk("t5_ovr_hold", 32'(ovr), 32'd1);

    // Test 6: one full frame (64 pixels) with a release before each burst pair
    fill_tab(16'h0033, 2'd2);
    for (int p = 0; p < 4; p++) begin
      pulse_release();
      send_burst("t6");
      send_burst("t6");
    end
    wait_write_addr(31, "t6_last_write");
    cycles(3);
    chk("t6_count", 32'(addr_log.size()), 32'd128);
    chk("t6_fe_once", 32'(fe_count(64, 127)), 32'd1);
    chk("t6_fe_last", 32'(fe_log[127]), 32'd1);
    chk("t6_addr_first", 32'(addr_log[64]), 32'd0);
    chk("t6_addr_mid", 32'(addr_log[100]), 32'd4);
    chk("t6_addr_last", 32'(addr_log[127]), 32'd31);
    chk("t6_fe_stray", 32'(fe_stray), 32'd0);
    chk("t6_ovr_hold", 32'(ovr), 32'd1);

    // Reset again: overrun clears; a release at zero occupancy is ignored
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_ovr", 32'(ovr), 32'd0);
    chk("rst2_addr", 32'(addr), 32'd0);
    chk("rst2_ready", 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    chk("rst2_wnd", 32'(wnd), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_release();
    fill_tab(16'h0011, 2'd2);
    for (int b = 0; b < 4; b++) send_burst("r2");
    wait_write_addr(31, "r2_last_write");
    cycles(3);
    chk("r2_wnd", 32'(wnd), 32'd1);
    chk("r2_ready", 32'(axi_if.pxconv_to_axi_ready_to_rd), 32'd0);
    chk("r2_count", 32'(addr_log.size()), 32'd160);
    chk("r2_addr_first", 32'(addr_log[128]), 32'd0);
    chk("r2_data", 32'(data_log[159]), 32'h0011);
    chk("r2_ovr", 32'(ovr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
